alu_operand_issue: RTL and testbench
====================================

Name: alu_operand_issue

Overview:
- Execute-stage issue block sitting directly upstream of the ALU.
- Accepts decoded instructions from the decode stage and resolves operand A and operand B. Sources are: register data with EX/WB forwarding, PC, or immediate.
- Normalises the 2-bit ALU op and presents registered ALUA/ALUB/ALUControl to the ALU over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput. A load-use interlock stalls decode when a forwarded value is not yet available.

Parameters:
- N, 32, datapath width; must match the ALU's N.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  block accepts this cycle; transfer when in_valid && in_ready.
- in_rs1_addr, in_rs2_addr  in  RA_W  source register addresses.
- in_rs1_data, in_rs2_data  in  N  register-file read data.
- in_pc  in  N  instruction PC.
- in_imm  in  N  sign-extended immediate.
- in_sel_a  in  1  0 = rs1, 1 = PC.
- in_sel_b  in  1  0 = rs2, 1 = imm.
- in_alu_op  in  2  00 = add, 01 = sub, others reserved.
- in_rd  in  RA_W  destination register.
- ex_fwd_en  in  1  EX/MEM stage will write ex_fwd_rd.
- ex_fwd_pend  in  1  EX/MEM result not yet available (load).
- ex_fwd_rd  in  RA_W  EX/MEM destination register.
- ex_fwd_data  in  N  EX/MEM result.
- wb_fwd_en  in  1  WB stage writes wb_fwd_rd.
- wb_fwd_rd  in  RA_W  WB destination register.
- wb_fwd_data  in  N  WB result.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_alua  out  N  to ALU ALUA.
- out_alub  out  N  to ALU ALUB.
- out_alucontrol  out  2  to ALU ALUControl.
- out_rd  out  RA_W  destination register, travels with the operands.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to EMPTY.
  - out_valid=0; out_alua, out_alub, out_rd = 0; out_alucontrol = 2'b00.
  - Skid entry is cleared.
  - No accept takes effect while rst_n is low.
  - Reset mid-transfer loses the in-flight entry with no partial update.
- Operand resolution (combinational on accept; one operand_fwd_mux per source):
  - Priority per source: EX match (ex_fwd_en && ex_fwd_rd==addr && addr!=0) > WB match (same form) > register data.
  - Register x0 always yields 0, regardless of rf data or forwarding.
  - ALUA = in_sel_a ? in_pc : fwd(rs1).
  - ALUB = in_sel_b ? in_imm : fwd(rs2).
  - Operands are sampled once, at accept, and frozen thereafter.
- Op normalisation: 00→00, 01→01, 10/11→00 (add), matching the ALU default arm.
- Interlock:
  - hazard = in_valid && ex_fwd_en && ex_fwd_pend && ex_fwd_rd!=0 && ((!in_sel_a && in_rs1_addr==ex_fwd_rd) || (!in_sel_b && in_rs2_addr==ex_fwd_rd)).
  - in_ready = !skid_full && !hazard && !flush.
- FSM (states EMPTY, ONE, FULL; acc = in_valid && in_ready; deq = out_valid && out_ready):
  - EMPTY: acc → ONE, output register loaded. Otherwise stay.
  - ONE: acc && !deq → FULL, skid loaded. !acc && deq → EMPTY. acc && deq → ONE, output register reloaded with the new entry. Otherwise stay.
  - FULL: in_ready=0. deq → ONE, skid moves to the output register. Otherwise stay.
  - flush (any state) → EMPTY next edge; accept and dequeue that cycle are discarded. flush has priority over all transitions.
- Outputs:
  - out_valid = (state != EMPTY).
  - Output fields are registered and held stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid when EMPTY. Sustained throughput is 1 per cycle with out_ready high.
- Ordering: strict FIFO, no reordering, no duplication.
- Width rules: all operands N bits; no extension is performed in this block.

Decomposition:
- alu_pkg holds:
  - ALU_OP_ADD = 2'b00, ALU_OP_SUB = 2'b01 (shared with the ALU).
  - typedef issue_t (alua, alub, alucontrol, rd).
  - typedef enum issue_state_t {EMPTY, ONE, FULL}.
- One sub-module: operand_fwd_mux (address, rf data, EX/WB forward fields → resolved N-bit value), instantiated twice.

Test Plan:
- Reset and basic issue: rs1=x3 (data 5), rs2=x4 (data 7), op 01, out_ready=1, no forwarding → next cycle out_valid=1, ALUA=5, ALUB=7, ALUControl=01; the ALU returns 0xFFFFFFFE.
- Forward priority: rs1=x6 with EX fwd x6=0x10 and WB fwd x6=0x20 → ALUA=0x10. With EX disabled → ALUA=0x20. With rs1=x0 and all fwd to x0=0xFF → ALUA=0.
- Load-use stall: ex_fwd_en=1, ex_fwd_pend=1, ex_fwd_rd=x9, incoming rs2=x9, sel_b=0 → in_ready=0. Drop pend and set ex_fwd_data=0x44 → accept, ALUB=0x44. Same case with sel_b=1 → no stall.
- Backpressure/skid: out_ready=0, send A and B back-to-back → state FULL, in_ready=0, out holds A. Raise out_ready → A then B on consecutive cycles, in_ready returns to 1.
- Flush in FULL with in_valid=1 → next cycle out_valid=0, state EMPTY, the offered entry is not captured.
- Async reset asserted mid-stream (between clock edges) → out_valid=0 immediately. After release, first accepted entry appears with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Package shared by the ALU operand issue block and the ALU.
// Holds the ALU opcode encodings, the issued-entry struct, the issue FSM
// state type, and the op normalisation helper.
package alu_pkg;

  // Datapath and register-address widths that issue_t is built on. The issue
  // block's N and RA_W parameters must be left at these values.
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;

  // One issued entry: exactly what the ALU and the writeback tag need.
  typedef struct packed {
    logic [DATA_W-1:0] alua;
    logic [DATA_W-1:0] alub;
    logic [1:0]        alucontrol;
    logic [REG_W-1:0]  rd;
  } issue_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } issue_state_t;

  // Reserved encodings fall back to add, matching the ALU's default arm.
  function automatic logic [1:0] norm_alu_op(input logic [1:0] op);
    return (op == ALU_OP_SUB) ? ALU_OP_SUB : ALU_OP_ADD;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one register source operand from forwarding and register-file data.
// Ports:
//   addr              source register address
//   rf_data           register-file read data for addr
//   ex_en/ex_rd/ex_data  EX/MEM forwarding fields
//   wb_en/wb_rd/wb_data  WB forwarding fields
//   value             resolved operand
// Priority: EX match > WB match > register file. x0 always resolves to 0.
module operand_fwd_mux #(
  parameter int N    = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] addr,
  input  logic [N-1:0]    rf_data,
  input  logic            ex_en,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [N-1:0]    ex_data,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [N-1:0]    wb_data,
  output logic [N-1:0]    value
);

  logic addr_nz;
  logic ex_hit;
  logic wb_hit;

  assign addr_nz = (addr != '0);
  assign ex_hit  = ex_en && (ex_rd == addr) && addr_nz;
  assign wb_hit  = wb_en && (wb_rd == addr) && addr_nz;

  always_comb begin
    value = rf_data;
    if (!addr_nz)    value = '0;
    else if (ex_hit) value = ex_data;
    else if (wb_hit) value = wb_data;
  end

endmodule

// File: rtl/alu_operand_issue.sv
// Execute-stage issue block feeding the ALU.
// Accepts decoded instructions (in_valid/in_ready), resolves operand A
// (rs1 or PC) and operand B (rs2 or immediate) with EX/WB forwarding,
// normalises the ALU op and presents registered operands to the ALU
// (out_valid/out_ready). A two-entry buffer (output register + skid)
// sustains one transfer per cycle; a load-use interlock holds off decode.
// Ports:
//   clk, rst_n, flush         clock, async active-low reset, sync flush
//   in_*                      decode-side instruction and handshake
//   ex_fwd_*, wb_fwd_*        forwarding sources
//   out_*                     ALU-side operands, control, rd and handshake
//   dbg_state                 current issue_state_t encoding
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a producer holds valid and its payload until that edge, and
// out_* are stable whenever out_valid && !out_ready.
module alu_operand_issue
  import alu_pkg::*;
#(
  parameter int N    = DATA_W,
  parameter int RA_W = REG_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [N-1:0]    in_rs1_data,
  input  logic [N-1:0]    in_rs2_data,
  input  logic [N-1:0]    in_pc,
  input  logic [N-1:0]    in_imm,
  input  logic            in_sel_a,
  input  logic            in_sel_b,
  input  logic [1:0]      in_alu_op,
  input  logic [RA_W-1:0] in_rd,
  input  logic            ex_fwd_en,
  input  logic            ex_fwd_pend,
  input  logic [RA_W-1:0] ex_fwd_rd,
  input  logic [N-1:0]    ex_fwd_data,
  input  logic            wb_fwd_en,
  input  logic [RA_W-1:0] wb_fwd_rd,
  input  logic [N-1:0]    wb_fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_alua,
  output logic [N-1:0]    out_alub,
  output logic [1:0]      out_alucontrol,
  output logic [RA_W-1:0] out_rd,
  output logic [1:0]      dbg_state
);

  issue_state_t state;
  issue_t       out_q;
  issue_t       skid_q;
  issue_t       new_entry;

  logic [N-1:0] rs1_val;
  logic [N-1:0] rs2_val;
  logic         hazard;
  logic         acc;
  logic         deq;

  operand_fwd_mux #(.N(N), .RA_W(RA_W)) u_fwd_rs1 (
    .addr    (in_rs1_addr),
    .rf_data (in_rs1_data),
    .ex_en   (ex_fwd_en),
    .ex_rd   (ex_fwd_rd),
    .ex_data (ex_fwd_data),
    .wb_en   (wb_fwd_en),
    .wb_rd   (wb_fwd_rd),
    .wb_data (wb_fwd_data),
    .value   (rs1_val)
  );

  operand_fwd_mux #(.N(N), .RA_W(RA_W)) u_fwd_rs2 (
    .addr    (in_rs2_addr),
    .rf_data (in_rs2_data),
    .ex_en   (ex_fwd_en),
    .ex_rd   (ex_fwd_rd),
    .ex_data (ex_fwd_data),
    .wb_en   (wb_fwd_en),
    .wb_rd   (wb_fwd_rd),
    .wb_data (wb_fwd_data),
    .value   (rs2_val)
  );

  // Stall only when a register source actually reads the pending load's rd;
  // a source replaced by PC/immediate does not care.
  assign hazard = in_valid && ex_fwd_en && ex_fwd_pend && (ex_fwd_rd != '0) &&
                  ((!in_sel_a && (in_rs1_addr == ex_fwd_rd)) ||
                   (!in_sel_b && (in_rs2_addr == ex_fwd_rd)));

  assign in_ready = (state != FULL) && !hazard && !flush;
  assign acc      = in_valid && in_ready;
  assign deq      = out_valid && out_ready;

  always_comb begin
    new_entry.alua       = in_sel_a ? in_pc  : rs1_val;
    new_entry.alub       = in_sel_b ? in_imm : rs2_val;
    new_entry.alucontrol = norm_alu_op(in_alu_op);
    new_entry.rd         = in_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            out_q <= new_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (acc && !deq) begin
            skid_q <= new_entry;
            state  <= FULL;
          end else if (acc && deq) begin
            out_q <= new_entry;
          end else if (deq) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (deq) begin
            out_q <= skid_q;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid      = (state != EMPTY);
  assign out_alua       = out_q.alua;
  assign out_alub       = out_q.alub;
  assign out_alucontrol = out_q.alucontrol;
  assign out_rd         = out_q.rd;
  assign dbg_state      = state;

endmodule

// File: tb/tb_alu_operand_issue.sv
module tb_alu_operand_issue;

  localparam int N    = 32;
  localparam int RA_W = 5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [RA_W-1:0] in_rs1_addr;
  logic [RA_W-1:0] in_rs2_addr;
  logic [N-1:0]    in_rs1_data;
  logic [N-1:0]    in_rs2_data;
  logic [N-1:0]    in_pc;
  logic [N-1:0]    in_imm;
  logic            in_sel_a;
  logic            in_sel_b;
  logic [1:0]      in_alu_op;
  logic [RA_W-1:0] in_rd;
  logic            ex_fwd_en;
  logic            ex_fwd_pend;
  logic [RA_W-1:0] ex_fwd_rd;
  logic [N-1:0]    ex_fwd_data;
  logic            wb_fwd_en;
  logic [RA_W-1:0] wb_fwd_rd;
  logic [N-1:0]    wb_fwd_data;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_alua;
  logic [N-1:0]    out_alub;
  logic [1:0]      out_alucontrol;
  logic [RA_W-1:0] out_rd;
  logic [1:0]      dbg_state;

  int checks;
  int errors;

  alu_operand_issue #(.N(N), .RA_W(RA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1_addr    (in_rs1_addr),
    .in_rs2_addr    (in_rs2_addr),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_sel_a       (in_sel_a),
    .in_sel_b       (in_sel_b),
    .in_alu_op      (in_alu_op),
    .in_rd          (in_rd),
    .ex_fwd_en      (ex_fwd_en),
    .ex_fwd_pend    (ex_fwd_pend),
    .ex_fwd_rd      (ex_fwd_rd),
    .ex_fwd_data    (ex_fwd_data),
    .wb_fwd_en      (wb_fwd_en),
    .wb_fwd_rd      (wb_fwd_rd),
    .wb_fwd_data    (wb_fwd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alua       (out_alua),
    .out_alub       (out_alub),
    .out_alucontrol (out_alucontrol),
    .out_rd         (out_rd),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached got running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_rs1_addr = '0;
    in_rs2_addr = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    in_pc       = 32'h0000_1000;
    in_imm      = 32'h0000_0ABC;
    in_sel_a    = 1'b0;
    in_sel_b    = 1'b0;
    in_alu_op   = 2'b00;
    in_rd       = '0;
    ex_fwd_en   = 1'b0;
    ex_fwd_pend = 1'b0;
    ex_fwd_rd   = '0;
    ex_fwd_data = '0;
    wb_fwd_en   = 1'b0;
    wb_fwd_rd   = '0;
    wb_fwd_data = '0;
  endtask

  task automatic set_instr(input logic [RA_W-1:0] rs1, input logic [N-1:0] d1,
                           input logic [RA_W-1:0] rs2, input logic [N-1:0] d2,
                           input logic sa, input logic sb,
                           input logic [1:0] op, input logic [RA_W-1:0] rd);
    in_rs1_addr = rs1;
    in_rs1_data = d1;
    in_rs2_addr = rs2;
    in_rs2_data = d2;
    in_sel_a    = sa;
    in_sel_b    = sb;
    in_alu_op   = op;
    in_rd       = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    set_instr(5'd3, 32'd5, 5'd4, 32'd7, 1'b0, 1'b0, 2'b01, 5'd1);
    in_valid = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_alua !== 32'd0) begin errors++; $display("FAIL reset_alua got %h want 0", out_alua); end
    checks++; if (out_alub !== 32'd0) begin errors++; $display("FAIL reset_alub got %h want 0", out_alub); end
    checks++; if (out_alucontrol !== 2'b00) begin errors++; $display("FAIL reset_ctrl got %b want 00", out_alucontrol); end
    checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", out_rd); end
    checks++; if (dbg_state !== ST_EMPTY) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept got %0b want 0", out_valid); end
  endtask

  task automatic test_basic();
    logic [N-1:0] res;
    out_ready = 1'b1;
    set_instr(5'd3, 32'd5, 5'd4, 32'd7, 1'b0, 1'b0, 2'b01, 5'd10);
    send();
    res = out_alua - out_alub;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    checks++; if (out_alua !== 32'd5) begin errors++; $display("FAIL basic_alua got %h want 5", out_alua); end
    checks++; if (out_alub !== 32'd7) begin errors++; $display("FAIL basic_alub got %h want 7", out_alub); end
    checks++; if (out_alucontrol !== 2'b01) begin errors++; $display("FAIL basic_ctrl got %b want 01", out_alucontrol); end
    checks++; if (out_rd !== 5'd10) begin errors++; $display("FAIL basic_rd got %0d want 10", out_rd); end
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL basic_alu_sub got %h want fffffffe", res); end
    // Back-to-back with reserved op 10, then op 11 using PC/immediate.
    set_instr(5'd1, 32'd2, 5'd2, 32'd3, 1'b0, 1'b0, 2'b10, 5'd11);
    send();
    checks++; if (out_alucontrol !== 2'b00) begin errors++; $display("FAIL op10_ctrl got %b want 00", out_alucontrol); end
    checks++; if (out_rd !== 5'd11) begin errors++; $display("FAIL op10_rd got %0d want 11", out_rd); end
    set_instr(5'd1, 32'd2, 5'd2, 32'd3, 1'b1, 1'b1, 2'b11, 5'd12);
    send();
    checks++; if (out_alucontrol !== 2'b00) begin errors++; $display("FAIL op11_ctrl got %b want 00", out_alucontrol); end
    checks++; if (out_alua !== 32'h0000_1000) begin errors++; $display("FAIL sel_pc_alua got %h want 00001000", out_alua); end
    checks++; if (out_alub !== 32'h0000_0ABC) begin errors++; $display("FAIL sel_imm_alub got %h want 00000abc", out_alub); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_forward();
    out_ready   = 1'b1;
    ex_fwd_en   = 1'b1; ex_fwd_rd = 5'd6; ex_fwd_data = 32'h10;
    wb_fwd_en   = 1'b1; wb_fwd_rd = 5'd6; wb_fwd_data = 32'h20;
    set_instr(5'd6, 32'h99, 5'd8, 32'h77, 1'b0, 1'b0, 2'b00, 5'd1);
    send();
    checks++; if (out_alua !== 32'h10) begin errors++; $display("FAIL fwd_ex_prio got %h want 10", out_alua); end
    checks++; if (out_alub !== 32'h77) begin errors++; $display("FAIL fwd_rf_b got %h want 77", out_alub); end
    ex_fwd_en = 1'b0;
    send();
    checks++; if (out_alua !== 32'h20) begin errors++; $display("FAIL fwd_wb got %h want 20", out_alua); end
    wb_fwd_rd = 5'd8; wb_fwd_data = 32'h33;
    send();
    checks++; if (out_alua !== 32'h99) begin errors++; $display("FAIL fwd_rf_a got %h want 99", out_alua); end
    checks++; if (out_alub !== 32'h33) begin errors++; $display("FAIL fwd_wb_b got %h want 33", out_alub); end
    ex_fwd_en = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'hFF;
    wb_fwd_en = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'hFF;
    set_instr(5'd0, 32'h55, 5'd0, 32'h66, 1'b0, 1'b0, 2'b00, 5'd2);
    send();
    checks++; if (out_alua !== 32'd0) begin errors++; $display("FAIL fwd_x0_a got %h want 0", out_alua); end
    checks++; if (out_alub !== 32'd0) begin errors++; $display("FAIL fwd_x0_b got %h want 0", out_alub); end
    idle_inputs();
    step();
  endtask

  task automatic test_load_use();
    out_ready   = 1'b1;
    ex_fwd_en   = 1'b1; ex_fwd_pend = 1'b1; ex_fwd_rd = 5'd9; ex_fwd_data = 32'h0;
    set_instr(5'd1, 32'h1, 5'd9, 32'h5, 1'b0, 1'b0, 2'b00, 5'd3);
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_b got %0b want 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_no_accept got %0b want 0", out_valid); end
    ex_fwd_pend = 1'b0; ex_fwd_data = 32'h44;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %0b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_alub !== 32'h44) begin errors++; $display("FAIL lu_fwd_b got %h want 44", out_alub); end
    // rs1 hazard, then removed by selecting PC/immediate for both sources.
    ex_fwd_pend = 1'b1;
    set_instr(5'd9, 32'h1, 5'd9, 32'h5, 1'b0, 1'b1, 2'b00, 5'd4);
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_a got %0b want 0", in_ready); end
    in_sel_a = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_imm_nostall got %0b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_alub !== 32'h0000_0ABC) begin errors++; $display("FAIL lu_imm_b got %h want 00000abc", out_alub); end
    checks++; if (out_rd !== 5'd4) begin errors++; $display("FAIL lu_imm_rd got %0d want 4", out_rd); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_instr(5'd1, 32'hA1, 5'd2, 32'hA2, 1'b0, 1'b0, 2'b01, 5'd1);
    send();
    set_instr(5'd1, 32'hB1, 5'd2, 32'hB2, 1'b0, 1'b0, 2'b00, 5'd2);
    send();
    set_instr(5'd1, 32'hC1, 5'd2, 32'hC2, 1'b0, 1'b0, 2'b00, 5'd3);
    in_valid = 1'b1;
    #1;
    checks++; if (dbg_state !== ST_FULL) begin errors++; $display("FAIL skid_full_state got %0d want 2", dbg_state); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready got %0b want 0", in_ready); end
    checks++; if (out_alua !== 32'hA1) begin errors++; $display("FAIL skid_head_a got %h want a1", out_alua); end
    step();
    checks++; if (out_alua !== 32'hA1 || out_alucontrol !== 2'b01) begin errors++; $display("FAIL skid_hold got %h/%b want a1/01", out_alua, out_alucontrol); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_alua !== 32'hB1 || out_alub !== 32'hB2) begin errors++; $display("FAIL skid_second got %h/%h want b1/b2", out_alua, out_alub); end
    checks++; if (out_rd !== 5'd2) begin errors++; $display("FAIL skid_second_rd got %0d want 2", out_rd); end
    checks++; if (dbg_state !== ST_ONE) begin errors++; $display("FAIL skid_one_state got %0d want 1", dbg_state); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back got %0b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_instr(5'd1, 32'hA1, 5'd2, 32'hA2, 1'b0, 1'b0, 2'b00, 5'd1);
    send();
    set_instr(5'd1, 32'hB1, 5'd2, 32'hB2, 1'b0, 1'b0, 2'b00, 5'd2);
    send();
    set_instr(5'd1, 32'hC1, 5'd2, 32'hC2, 1'b0, 1'b0, 2'b00, 5'd3);
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b want 0", in_ready); end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    checks++; if (dbg_state !== ST_EMPTY) begin errors++; $display("FAIL flush_state got %0d want 0", dbg_state); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_capture got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_instr(5'd1, 32'hE1, 5'd2, 32'hE2, 1'b0, 1'b0, 2'b01, 5'd5);
    send();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %0b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b want 0", out_valid); end
    checks++; if (out_alua !== 32'd0) begin errors++; $display("FAIL areset_alua got %h want 0", out_alua); end
    step();
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    set_instr(5'd3, 32'hD1, 5'd4, 32'hD2, 1'b0, 1'b0, 2'b00, 5'd7);
    in_valid = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_before_edge got %0b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_latency got %0b want 1", out_valid); end
    checks++; if (out_alua !== 32'hD1 || out_rd !== 5'd7) begin errors++; $display("FAIL areset_entry got %h/%0d want d1/7", out_alua, out_rd); end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_forward();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
